// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage of the MIPS pipeline. Holds the PC, presents it to a
//   combinational, word-indexed instruction memory, and registers the
//   returned word into the IF/ID pipeline register. Handles boot, stall,
//   branch redirect, flush, halt detection and a saturating fetch counter.
//
// Ports
//   Clk, Reset            rising-edge clock, async active-high reset
//   Stall                 hold PC, IF/ID and FetchCount
//   Flush                 load a bubble into IF/ID (PC still advances)
//   BranchTaken/Target    redirect fetch; target low bits dropped
//   Instruction           memory word for Address, same cycle
//   Address               current PC (straight from the PC register)
//   IF_ID_*               registered instruction, PC+4, valid
//   Halted                high while fetch is stopped on HALT_WORD
//   FetchCount            valid instructions latched, saturating
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] Address,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic [15:0] FetchCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;        // wraps modulo 2^32
    assign target   = BranchTarget & ~32'h3;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;

        case (state_q)
            // IF/ID already holds the reset bubble; only the PC may move.
            BOOT: begin
                state_d = RUN;
                if (BranchTaken) pc_d = target;
            end

            RUN: begin
                if (BranchTaken) begin
                    pc_d    = target;
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    // hold everything
                end else if (Instruction == HALT_WORD) begin
                    // halt word is swallowed: never decoded, never counted
                    state_d = HALT;
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else begin
                    pc_d = pc_plus4;
                    if (Flush) begin
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = Instruction;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    end
                end
            end

            // The halt word may sit on a wrong path, so a branch resumes fetch.
            // IF/ID already holds the bubble latched on entry.
            HALT: begin
                if (BranchTaken) begin
                    state_d = RUN;
                    pc_d    = target;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign Address           = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pc4_q;
    assign IF_ID_Valid       = valid_q;
    assign Halted            = (state_q == HALT);
    assign FetchCount        = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction-memory interface: holds the program counter, drives the 32-bit byte address to the instruction memory every cycle, samples the returned instruction word, and registers it into the IF/ID pipeline register. The instruction memory is combinational and word-indexed by Address[31:2]. This unit therefore owns all sequencing: boot, stall, branch redirect, flush, halt detection and a fetch counter. It sits between the instruction memory and the decode stage of the MIPS pipeline.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are always 0.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hazard stall from decode; hold PC and IF/ID.
- Flush  input  1  replace the IF/ID contents with a bubble at the next edge.
- BranchTaken  input  1  redirect fetch at the next edge.
- BranchTarget  input  32  redirect address; bits [1:0] forced to 00 internally.
- Instruction  input  32  word returned by instruction memory for Address (same cycle).
- Address  output  32  current PC, driven directly from the PC register.
- IF_ID_Instruction  output  32  registered fetched instruction.
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
- Halted  output  1  high while in HALT state.
- FetchCount  output  16  number of valid instructions latched into IF/ID; saturates at 16'hFFFF.

## Operation
- States: BOOT, RUN, HALT. Reset forces BOOT.
- BOOT: lasts exactly one cycle. Address = RESET_PC. Nothing is latched and PC holds. The next edge enters RUN, unless BranchTaken is set, which redirects and enters RUN.
- RUN edge actions, in priority order:
  1. BranchTaken: PC <= {BranchTarget[31:2],2'b00}; IF/ID <= bubble; state RUN. Stall and Flush are ignored.
  2. Stall: PC, IF/ID, FetchCount hold.
  3. Instruction == HALT_WORD: PC holds; IF/ID <= bubble; state HALT.
  4. Otherwise: PC <= PC+4.
     - Flush: IF/ID <= bubble.
     - No Flush: IF/ID <= {Instruction, PC+4, Valid=1}, and FetchCount increments.
- A bubble is IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
- HALT: PC and FetchCount hold; IF/ID holds the bubble; Halted=1.
  - BranchTaken redirects as in RUN and returns to RUN, because the halt word may be wrong-path.
  - Stall and Flush have no effect.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. IF_ID_PCPlus4 wraps identically.
- The halt word is never passed to decode and never counted.

## Timing
- Reset values (asserted asynchronously, held while Reset=1):
  - Address=RESET_PC
  - IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0
  - Halted=0, FetchCount=0
  - state=BOOT
- Reset mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.
- Address changes only on a rising Clk edge or on Reset. The memory word for Address must be valid before the next edge (single-cycle combinational read).
- Fetch latency: the word at Address during cycle n appears on IF_ID_Instruction after edge n+1.
- Branch penalty: the edge that samples BranchTaken loads the target and inserts one bubble. The target instruction reaches IF/ID on the following edge.
- Halted rises on the same edge that latches the bubble for HALT_WORD.
- Stall is level-sensitive. Every stalled edge holds all state, including FetchCount.

## Test plan
- Reset release, Instruction = memory[i]=i*3, no stalls:
  - Address goes 0, 0 (BOOT), 4, 8, ...
  - IF_ID_Instruction goes 0, 3, 6, with IF_ID_PCPlus4 = 4, 8, 12.
  - FetchCount increments once per edge after BOOT.
- Stall high for 3 edges at PC=8:
  - Address stays 8; IF/ID holds {3, 8, 1}; FetchCount is unchanged.
  - After release, PC=12 and IF_ID_Instruction=6.
- BranchTaken with BranchTarget=32'h0000_0043, Stall=1 on the same edge:
  - Address=32'h40; IF_ID_Valid=0.
  - Next edge: IF_ID_PCPlus4=32'h44.
- Flush alone at PC=16: Address advances to 20; IF/ID becomes a bubble; FetchCount does not increment.
- Halt, then redirect:
  - Instruction=32'hFFFF_FFFF at PC=24: Halted=1, PC stays 24, IF_ID_Valid=0.
  - Further edges change nothing.
  - BranchTaken to 32'h8: Halted=0, Address=8.
- Wrap and reset:
  - BranchTarget=32'hFFFF_FFFC, then one RUN edge: Address=0, IF_ID_PCPlus4=0.
  - Assert Reset mid-cycle: outputs return to reset values immediately.
